fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/nrisc_pkg.sv | 15 +
 rtl/fetch_unit_pc_next.sv | 18 +
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_pkg.sv
// Shared widths, fetch FSM encoding and reset PC for the nrisc core.
package nrisc_pkg;

  localparam int WORD_W = 8;
  localparam int IMM_W  = 3;

  localparam logic [WORD_W-1:0] RESET_PC_DEF = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC adder: branch offset or sequential +1, modulo 2^WORD_W.
module pc_next
  import nrisc_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] imm_ext,
  input  logic              branch_taken,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] incr;

  always_comb begin
    incr    = branch_taken ? imm_ext : WORD_W'(1);
    next_pc = pc + incr;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (IDLE/FETCH/HOLD) with stall and PC-relative branch.
// Optional ack timeout with sticky fault enabled by `define FETCH_TIMEOUT_EN.
module fetch_unit
  import nrisc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC    = RESET_PC_DEF,
  parameter int                TIMEOUT_CYC = 15
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] imm_ext,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [IMM_W-1:0]  imm_field,
  output logic              fetch_fault
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 15) begin : g_bad_timeout
    $error("TIMEOUT_CYC out of range 1..15");
  end

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] CNT_LIM = 4'(TIMEOUT_CYC - 1);
  logic [3:0] cnt_q, cnt_d;
  logic       fault_q, fault_d;
`endif

  pc_next u_pc_next (
    .pc           (pc_q),
    .imm_ext      (imm_ext),
    .branch_taken (branch_taken),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    fault_d = fault_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef FETCH_TIMEOUT_EN
        // a latched fault parks the unit until reset
        if (!fault_q) state_d = ST_FETCH;
`else
        state_d = ST_FETCH;
`endif
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          valid_d = 1'b1;
          state_d = ST_HOLD;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = 4'd0;
`endif
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_LIM) begin
          fault_d = 1'b1;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      ST_HOLD: begin
        if (!stall) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= 4'd0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
`endif
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign imm_field   = instr_q[IMM_W-1:0];
`ifdef FETCH_TIMEOUT_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       stall;
  logic       branch_taken;
  logic [7:0] imm_ext;
  logic [7:0] pc;
  logic [7:0] instr;
  logic       instr_valid;
  logic [2:0] imm_field;
  logic       fetch_fault;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] mem [256];

  always #5 clock = ~clock;

  assign imem_data = mem[imem_addr];

  fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .stall        (stall),
    .branch_taken (branch_taken),
    .imm_ext      (imm_ext),
    .pc           (pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .imm_field    (imm_field),
    .fetch_fault  (fetch_fault)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic a, input logic s,
                      input logic b, input logic [7:0] im);
    imem_ack     = a;
    stall        = s;
    branch_taken = b;
    imm_ext      = im;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    reset = 1'b0;
    n_chk++;
    if (pc !== 8'h00 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
        instr !== 8'h00 || fetch_fault !== 1'b0)
      $display("FAIL reset_state pc=%h req=%b v=%b instr=%h flt=%b exp 00/0/0/00/0",
               pc, imem_req, instr_valid, instr, fetch_fault);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL reset_req2 req=%b addr=%h exp 1/00", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_ack_wait();
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++;
    if (imem_req !== 1'b1 || pc !== 8'h00 || instr_valid !== 1'b0)
      $display("FAIL ack_wait req=%b pc=%h v=%b exp 1/00/0",
               imem_req, pc, instr_valid);
    else n_pass++;
  endtask

  task automatic test_seq_fetch();
    step(1'b1, 1'b1, 1'b0, 8'h00);
    n_chk++;
    if (instr !== 8'hA5 || imm_field !== 3'b101 || instr_valid !== 1'b1 ||
        imem_req !== 1'b0)
      $display("FAIL seq_capture instr=%h imm=%b v=%b req=%b exp a5/101/1/0",
               instr, imm_field, instr_valid, imem_req);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++;
    if (imem_addr !== 8'h01 || imem_req !== 1'b1 || instr_valid !== 1'b0)
      $display("FAIL seq_next addr=%h req=%b v=%b exp 01/1/0",
               imem_addr, imem_req, instr_valid);
    else n_pass++;
  endtask

  task automatic test_branch_wrap();
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h0F);
    n_chk++;
    if (imem_addr !== 8'h10)
      $display("FAIL br_fwd addr=%h exp 10", imem_addr);
    else n_pass++;
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'hFE);
    n_chk++;
    if (imem_addr !== 8'h0E)
      $display("FAIL br_back addr=%h exp 0e", imem_addr);
    else n_pass++;
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'hF1);
    n_chk++;
    if (imem_addr !== 8'hFF)
      $display("FAIL br_to_ff addr=%h exp ff", imem_addr);
    else n_pass++;
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h77);
    n_chk++;
    if (imem_addr !== 8'h00)
      $display("FAIL wrap addr=%h exp 00", imem_addr);
    else n_pass++;
  endtask

  task automatic test_stall_branch();
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h20);
    n_chk++;
    if (imem_addr !== 8'h20)
      $display("FAIL to_20 addr=%h exp 20", imem_addr);
    else n_pass++;
    step(1'b1, 1'b1, 1'b1, 8'h03);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'h03);
      n_chk++;
      if (pc !== 8'h20 || instr !== 8'h7A || instr_valid !== 1'b1 ||
          imem_req !== 1'b0)
        $display("FAIL stall_hold%0d pc=%h instr=%h v=%b req=%b exp 20/7a/1/0",
                 i, pc, instr, instr_valid, imem_req);
      else n_pass++;
    end
    step(1'b0, 1'b0, 1'b1, 8'h03);
    n_chk++;
    if (imem_addr !== 8'h23 || instr_valid !== 1'b0 || imem_req !== 1'b1)
      $display("FAIL stall_release addr=%h v=%b req=%b exp 23/0/1",
               imem_addr, instr_valid, imem_req);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    n_chk++;
    if (instr !== 8'h00 || pc !== 8'h00 || instr_valid !== 1'b0 ||
        imem_req !== 1'b0)
      $display("FAIL reset_mid instr=%h pc=%h v=%b req=%b exp 00/00/0/0",
               instr, pc, instr_valid, imem_req);
    else n_pass++;
  endtask

  task automatic test_timeout();
    step(1'b0, 1'b0, 1'b0, 8'h00);
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1)
      $display("FAIL to_pre flt=%b req=%b exp 0/1", fetch_fault, imem_req);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0)
      $display("FAIL to_hit flt=%b req=%b exp 1/0", fetch_fault, imem_req);
    else n_pass++;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    n_chk++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL to_sticky flt=%b req=%b v=%b exp 1/0/0",
               fetch_fault, imem_req, instr_valid);
    else n_pass++;
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    n_chk++;
    if (fetch_fault !== 1'b0)
      $display("FAIL to_clear flt=%b exp 0", fetch_fault);
    else n_pass++;
`else
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || pc !== 8'h00)
      $display("FAIL no_timeout flt=%b req=%b pc=%h exp 0/1/00",
               fetch_fault, imem_req, pc);
    else n_pass++;
    step(1'b1, 1'b1, 1'b0, 8'h00);
    n_chk++;
    if (instr !== 8'hA5 || instr_valid !== 1'b1)
      $display("FAIL late_ack instr=%h v=%b exp a5/1", instr, instr_valid);
    else n_pass++;
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0]       = 8'hA5;
    reset        = 1'b1;
    imem_ack     = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    imm_ext      = 8'h00;
    test_reset();
    test_ack_wait();
    test_seq_fetch();
    test_branch_wrap();
    test_stall_branch();
    test_reset_mid_fetch();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
